// File: rtl/branch_update_scheduler.sv
// branch_update_scheduler
// Queues BHT/BTB update requests from ID-stage branch resolution and schedules them onto
// the single-ported predictor tables. IF lookups win the port unless the queue is full or
// the queue head has lost arbitration MAX_WAIT cycles in a row.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   upd_bht_en/upd_btb_en         enqueue request (BHT and/or BTB write)
//   upd_pc/upd_taken/upd_target   update payload
//   upd_ready                     queue can accept this cycle
//   fetch_req                     IF wants the table port
//   fetch_grant/stall_fetch       IF owns the port / IF denied and holds its PC
//   tbl_wen_bht/tbl_wen_btb       table write strobes
//   tbl_pc/tbl_taken/tbl_target   table write payload (zero when not writing)
//   pending                       occupied queue entries

module branch_update_scheduler #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_bht_en,
    input  logic                     upd_btb_en,
    input  logic [15:0]              upd_pc,
    input  logic                     upd_taken,
    input  logic [15:0]              upd_target,
    output logic                     upd_ready,
    input  logic                     fetch_req,
    output logic                     fetch_grant,
    output logic                     stall_fetch,
    output logic                     tbl_wen_bht,
    output logic                     tbl_wen_btb,
    output logic [15:0]              tbl_pc,
    output logic                     tbl_taken,
    output logic [15:0]              tbl_target,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [DEPTH-1:0] q_bht, q_btb, q_taken;
    logic [15:0]      q_pc     [DEPTH];
    logic [15:0]      q_target [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] pending_q;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    logic enq, drain, force_drain;

    assign pending = pending_q;
    assign enq     = (upd_bht_en | upd_btb_en) & upd_ready & ~rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
            assert ((state_q == StIdle) == (pending_q == '0));
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enq) state_d = StActive;
            StActive: if (pending_q == CW'(1) && drain && !enq) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Arbitration and table outputs; gated by rst so nothing is written in a reset cycle
    always_comb begin
        upd_ready   = (pending_q != FULL);
        force_drain = (pending_q == FULL) | (wait_cnt_q == WMAX);
        drain       = ~rst & (pending_q != '0) & (~fetch_req | force_drain);
        fetch_grant = fetch_req & ~drain;
        stall_fetch = fetch_req & drain;
        tbl_wen_bht = 1'b0;
        tbl_wen_btb = 1'b0;
        tbl_pc      = '0;
        tbl_taken   = 1'b0;
        tbl_target  = '0;
        if (drain) begin
            tbl_wen_bht = q_bht[rd_ptr_q];
            tbl_wen_btb = q_btb[rd_ptr_q];
            tbl_pc      = q_pc[rd_ptr_q];
            tbl_taken   = q_taken[rd_ptr_q];
            tbl_target  = q_target[rd_ptr_q];
        end
    end

    // Head-starvation counter; head loses only when fetch_req wins with entries pending
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (drain || state_q == StIdle) begin
            wait_cnt_d = '0;
        end else if (fetch_req && wait_cnt_q != WMAX) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (enq)   wr_ptr_q <= wr_ptr_q + PW'(1);
            if (drain) rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({enq, drain})
                2'b10:   pending_q <= pending_q + CW'(1);
                2'b01:   pending_q <= pending_q - CW'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only read while counted in pending
    always_ff @(posedge clk) begin
        if (enq) begin
            q_bht[wr_ptr_q]    <= upd_bht_en;
            q_btb[wr_ptr_q]    <= upd_btb_en;
            q_pc[wr_ptr_q]     <= upd_pc;
            q_taken[wr_ptr_q]  <= upd_taken;
            q_target[wr_ptr_q] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_update_scheduler.sv
module tb_branch_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_bht_en, upd_btb_en, upd_taken, fetch_req;
    logic [15:0] upd_pc, upd_target;
    logic        upd_ready, fetch_grant, stall_fetch, tbl_wen_bht, tbl_wen_btb, tbl_taken;
    logic [15:0] tbl_pc, tbl_target;
    logic [2:0]  pending;

    int n_assert = 0;
    int n_fail   = 0;

    branch_update_scheduler #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_bht_en  (upd_bht_en),
        .upd_btb_en  (upd_btb_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_ready   (upd_ready),
        .fetch_req   (fetch_req),
        .fetch_grant (fetch_grant),
        .stall_fetch (stall_fetch),
        .tbl_wen_bht (tbl_wen_bht),
        .tbl_wen_btb (tbl_wen_btb),
        .tbl_pc      (tbl_pc),
        .tbl_taken   (tbl_taken),
        .tbl_target  (tbl_target),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic b, input logic t, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tgt);
        upd_bht_en = b;
        upd_btb_en = t;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
    endtask

    initial begin
        rst = 1'b1;
        fetch_req = 1'b0;
        upd(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state, IF owns the port
        fetch_req = 1'b1;
        settle();
        chk("rst_grant", 32'(fetch_grant), 32'd1);
        chk("rst_stall", 32'(stall_fetch), 32'd0);
        chk("rst_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(upd_ready), 32'd1);

        // Single BHT update, no bypass, written the following cycle
        fetch_req = 1'b0;
        upd(1'b1, 1'b0, 16'h0040, 1'b1, 16'h0080);
        settle();
        chk("nobypass_wen", 32'(tbl_wen_bht), 32'd0);
        tick();
        upd(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        settle();
        chk("single_pending", 32'(pending), 32'd1);
        chk("single_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'b10);
        chk("single_pc", 32'(tbl_pc), 32'h0040);
        chk("single_taken", 32'(tbl_taken), 32'd1);
        chk("single_tgt", 32'(tbl_target), 32'h0080);
        tick();
        settle();
        chk("single_empty", 32'(pending), 32'd0);
        chk("single_idle_pc", 32'(tbl_pc), 32'h0);

        // Aging: head loses 8 cycles, then forced on the 9th
        fetch_req = 1'b1;
        upd(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0200);
        tick();
        upd(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("age_grant", 32'({fetch_grant, stall_fetch, tbl_wen_btb}), 32'b100);
            tick();
        end
        settle();
        chk("age_force", 32'({fetch_grant, stall_fetch, tbl_wen_btb}), 32'b011);
        chk("age_pc", 32'(tbl_pc), 32'h0100);
        chk("age_tgt", 32'(tbl_target), 32'h0200);
        tick();
        settle();
        chk("age_empty", 32'(pending), 32'd0);

        // Fill the queue under fetch pressure
        for (int i = 0; i < 4; i++) begin
            upd(1'b1, 1'b1, 16'h1000 + 16'(i), 1'b1, 16'h3000 + 16'(i));
            settle();
            chk("fill_ready", 32'(upd_ready), 32'd1);
            tick();
        end
        // Full: forced drain, enqueue attempt refused
        upd(1'b1, 1'b0, 16'h2000, 1'b0, 16'h4000);
        settle();
        chk("full_pending", 32'(pending), 32'd4);
        chk("full_ready", 32'(upd_ready), 32'd0);
        chk("full_stall", 32'({fetch_grant, stall_fetch}), 32'b01);
        chk("full_pc0", 32'(tbl_pc), 32'h1000);
        chk("full_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'b11);
        tick();
        settle();
        chk("refused_pending", 32'(pending), 32'd3);
        chk("retry_ready", 32'(upd_ready), 32'd1);
        chk("retry_grant", 32'({fetch_grant, tbl_wen_bht}), 32'b10);
        tick();
        upd(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        settle();
        chk("refill_pending", 32'(pending), 32'd4);
        chk("refill_stall", 32'(stall_fetch), 32'd1);
        chk("fifo_pc1", 32'(tbl_pc), 32'h1001);
        tick();
        fetch_req = 1'b0;
        settle();
        chk("fifo_pc2", 32'(tbl_pc), 32'h1002);
        tick();
        settle();
        chk("fifo_pc3", 32'(tbl_pc), 32'h1003);
        tick();
        settle();
        chk("wrap_pc", 32'(tbl_pc), 32'h2000);
        chk("wrap_tgt", 32'(tbl_target), 32'h4000);
        chk("wrap_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'b10);
        tick();
        settle();
        chk("drained", 32'(pending), 32'd0);
        chk("drained_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'd0);

        // Reset with three entries pending
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upd(1'b1, 1'b0, 16'h5000 + 16'(i), 1'b0, 16'h0);
            tick();
        end
        upd(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        settle();
        chk("pre_rst_pending", 32'(pending), 32'd3);
        rst = 1'b1;
        settle();
        chk("in_rst_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'd0);
        chk("in_rst_grant", 32'({fetch_grant, stall_fetch}), 32'b10);
        tick();
        rst = 1'b0;
        fetch_req = 1'b0;
        settle();
        chk("post_rst_pending", 32'(pending), 32'd0);
        chk("post_rst_ready", 32'(upd_ready), 32'd1);
        chk("post_rst_wen", 32'({tbl_wen_bht, tbl_wen_btb}), 32'd0);
        tick();
        settle();
        chk("post_rst_quiet", 32'({tbl_wen_bht, tbl_wen_btb, pending}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
